switch_allocator: RTL

Switch-allocation stage directly downstream of route computation in the chiplet switch. It takes each input buffer's allocate request and requested outport and arbitrates, per outport, among buffers that want the same outport, using round-robin. A winning buffer keeps its outport, wormhole style, until the crossbar signals that the buffer's tail flit has left. Its registered outputs drive crossbar select and buffer dequeue enables.

---
 rtl/switch_allocator_if.sv | 28 ++
 rtl/switch_allocator.sv | 114 +++++++++++
 2 files changed

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between route computation, the switch allocator and the crossbar.
// master drives requests and tail-flit completions; slave (the allocator) returns bindings.
interface switch_allocator_if #(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = 5
);
    localparam int SELECT_SIZE  = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1);
    localparam int BUF_SEL_SIZE = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1);

    logic [NUM_BUFFERS-1:0]                    allocate;
    logic [NUM_BUFFERS-1:0][SELECT_SIZE-1:0]   out_sel;
    logic [NUM_BUFFERS-1:0]                    pkt_done;
    logic [NUM_BUFFERS-1:0]                    granted;
    logic [NUM_BUFFERS-1:0]                    grant_pulse;
    logic [NUM_BUFFERS-1:0][SELECT_SIZE-1:0]   buffer_dst;
    logic [NUM_OUTPORTS-1:0]                   outport_busy;
    logic [NUM_OUTPORTS-1:0][BUF_SEL_SIZE-1:0] outport_src;

    modport master (
        output allocate, out_sel, pkt_done,
        input  granted, grant_pulse, buffer_dst, outport_busy, outport_src
    );

    modport slave (
        input  allocate, out_sel, pkt_done,
        output granted, grant_pulse, buffer_dst, outport_busy, outport_src
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-outport round-robin switch allocator with wormhole hold until the bound buffer's tail leaves.
// Latency: request at t -> grant visible at t+1; release at t -> outport re-arbitrates at t+1.
// Backpressure: a losing or blocked request simply waits; allocate is ignored while the buffer is granted.
module switch_allocator #(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    switch_allocator_if.slave    bus
);
    localparam int SELECT_SIZE  = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1);
    localparam int BUF_SEL_SIZE = $clog2(NUM_BUFFERS) + (NUM_BUFFERS == 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } port_state_t;

    port_state_t [NUM_OUTPORTS-1:0]                   state_q;
    logic        [NUM_OUTPORTS-1:0][BUF_SEL_SIZE-1:0] ptr_q;
    logic        [NUM_OUTPORTS-1:0][BUF_SEL_SIZE-1:0] src_q;
    logic        [NUM_BUFFERS-1:0]                    granted_q;
    logic        [NUM_BUFFERS-1:0]                    pulse_q;
    logic        [NUM_BUFFERS-1:0][SELECT_SIZE-1:0]   dst_q;

    logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0]  elig;
    logic [NUM_OUTPORTS-1:0]                   win_vld;
    logic [NUM_OUTPORTS-1:0][BUF_SEL_SIZE-1:0] win_idx;

    // Out-of-range out_sel never matches any o below NUM_OUTPORTS, so it drops out here.
    always_comb begin
        elig = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                elig[o][b] = bus.allocate[b] && !granted_q[b] &&
                             (bus.out_sel[b] == SELECT_SIZE'(o));
            end
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        win_vld = '0;
        win_idx = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            if (state_q[o] == ST_IDLE) begin
                for (int k = 0; k < NUM_BUFFERS; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= NUM_BUFFERS) begin
                        idx = idx - NUM_BUFFERS;
                    end
                    if (!win_vld[o] && elig[o][idx]) begin
                        win_vld[o] = 1'b1;
                        win_idx[o] = BUF_SEL_SIZE'(idx);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= {NUM_OUTPORTS{ST_IDLE}};
            ptr_q     <= '0;
            src_q     <= '0;
            granted_q <= '0;
            pulse_q   <= '0;
            dst_q     <= '0;
        end else begin
            pulse_q <= '0;
            // pkt_done only matters for a buffer that actually holds an outport.
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                if (granted_q[b] && bus.pkt_done[b]) begin
                    granted_q[b] <= 1'b0;
                end
            end
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                case (state_q[o])
                    ST_IDLE: begin
                        if (win_vld[o]) begin
                            state_q[o]            <= ST_BUSY;
                            src_q[o]              <= win_idx[o];
                            ptr_q[o]              <= (int'(win_idx[o]) == NUM_BUFFERS - 1) ?
                                                     '0 : win_idx[o] + 1'b1;
                            granted_q[win_idx[o]] <= 1'b1;
                            pulse_q[win_idx[o]]   <= 1'b1;
                            dst_q[win_idx[o]]     <= SELECT_SIZE'(o);
                        end
                    end
                    ST_BUSY: begin
                        if (bus.pkt_done[src_q[o]]) begin
                            state_q[o] <= ST_IDLE;
                        end
                    end
                    default: state_q[o] <= ST_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        bus.outport_busy = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            bus.outport_busy[o] = (state_q[o] == ST_BUSY);
        end
    end

    assign bus.granted     = granted_q;
    assign bus.grant_pulse = pulse_q;
    assign bus.buffer_dst  = dst_q;
    assign bus.outport_src = src_q;
endmodule
